hiscore_restore: RTL



---
 rtl/hiscore_restore.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hiscore_restore.sv
// Captures hiscore config/data from the ioctl stream, polls game RAM for marker bytes, then writes saved bytes back.
// Optional HISCORE_PAUSE_EN adds pause_cpu, high from write-back start through DONE.
module hiscore_restore #(
  parameter int RAM_AW         = 10,
  parameter int DATA_AW        = 8,
  parameter int CHECK_INTERVAL = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [7:0]        ram_dout,
  output logic [RAM_AW-1:0] ram_address,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_access,
`ifdef HISCORE_PAUSE_EN
  output logic              pause_cpu,
`endif
  output logic              restored
);

  typedef enum logic [2:0] {IDLE, WAIT, CHK_S, CHK_E, WRITE, DONE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(CHECK_INTERVAL - 1);

  logic [23:0] base_tab  [16];
  logic [7:0]  len_tab   [16];
  logic [7:0]  start_tab [16];
  logic [7:0]  end_tab   [16];
  logic [7:0]  buffer    [2**DATA_AW];

  state_t             state;
  logic [15:0]        wait_cnt;
  logic               phase;
  logic               pre;
  logic [3:0]         entry;
  logic [7:0]         offset;
  logic [DATA_AW-1:0] ptr;
  logic [4:0]         entry_cnt;
  logic               cfg_loaded, data_loaded;
  logic               dl_q;
  logic [7:0]         dl_index;
  logic               pause;

  logic        cfg_wr, data_wr, dl_rise, dl_fall, more;
  logic [23:0] cur_base, end_addr, nxt_addr, nxt_base;

  assign cfg_wr   = ioctl_download && ioctl_wr && (ioctl_index == 8'd3);
  assign data_wr  = ioctl_download && ioctl_wr && (ioctl_index == 8'd4);
  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign cur_base = base_tab[entry];
  assign nxt_base = base_tab[entry + 4'd1];
  assign end_addr = cur_base + {16'd0, len_tab[entry]} - 24'd1;
  assign nxt_addr = cur_base + {16'd0, offset} + 24'd1;
  // A zero-length entry ends the table even if later entries were written.
  assign more = (entry != 4'hF) && (({1'b0, entry} + 5'd1) < entry_cnt) &&
                (len_tab[entry + 4'd1] != 8'd0);

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      case (ioctl_addr[2:0])
        3'd1: base_tab[ioctl_addr[6:3]][23:16] <= ioctl_dout;
        3'd2: base_tab[ioctl_addr[6:3]][15:8]  <= ioctl_dout;
        3'd3: base_tab[ioctl_addr[6:3]][7:0]   <= ioctl_dout;
        3'd4: len_tab[ioctl_addr[6:3]]         <= ioctl_dout;
        3'd5: start_tab[ioctl_addr[6:3]]       <= ioctl_dout;
        3'd6: end_tab[ioctl_addr[6:3]]         <= ioctl_dout;
        default: ;
      endcase
    end
    if (data_wr) buffer[ioctl_addr[DATA_AW-1:0]] <= ioctl_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      phase       <= 1'b0;
      pre         <= 1'b0;
      entry       <= '0;
      offset      <= '0;
      ptr         <= '0;
      entry_cnt   <= '0;
      cfg_loaded  <= 1'b0;
      data_loaded <= 1'b0;
      dl_q        <= 1'b0;
      dl_index    <= '0;
      pause       <= 1'b0;
      ram_address <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      ram_access  <= 1'b0;
      restored    <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (ioctl_download) dl_index <= ioctl_index;
      if (dl_fall && dl_index == 8'd3) cfg_loaded  <= 1'b1;
      if (dl_fall && dl_index == 8'd4) data_loaded <= 1'b1;
      if (dl_rise && (ioctl_index == 8'd3 || ioctl_index == 8'd4)) restored <= 1'b0;

      if (dl_rise && ioctl_index == 8'd3)
        entry_cnt <= '0;
      else if (cfg_wr && ({1'b0, ioctl_addr[6:3]} >= entry_cnt))
        entry_cnt <= {1'b0, ioctl_addr[6:3]} + 5'd1;

      // Any download while active releases the RAM port on the next edge.
      if (ioctl_download && state != IDLE) begin
        state      <= IDLE;
        ram_we     <= 1'b0;
        ram_access <= 1'b0;
        pause      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_loaded && data_loaded && !ioctl_download && !restored &&
                entry_cnt != 5'd0 && len_tab[0] != 8'd0) begin
              state    <= WAIT;
              wait_cnt <= '0;
            end
          end
          WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state       <= CHK_S;
              entry       <= '0;
              phase       <= 1'b0;
              ram_access  <= 1'b1;
              ram_address <= base_tab[0][RAM_AW-1:0];
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
          CHK_S: begin
            if (!phase) begin
              phase <= 1'b1;
            end else if (ram_dout == start_tab[entry]) begin
              state       <= CHK_E;
              phase       <= 1'b0;
              ram_address <= end_addr[RAM_AW-1:0];
            end else begin
              state      <= WAIT;
              wait_cnt   <= '0;
              ram_access <= 1'b0;
            end
          end
          CHK_E: begin
            if (!phase) begin
              phase <= 1'b1;
            end else if (ram_dout != end_tab[entry]) begin
              state      <= WAIT;
              wait_cnt   <= '0;
              ram_access <= 1'b0;
            end else if (more) begin
              state       <= CHK_S;
              entry       <= entry + 4'd1;
              phase       <= 1'b0;
              ram_address <= nxt_base[RAM_AW-1:0];
            end else begin
              state  <= WRITE;
              entry  <= '0;
              offset <= '0;
              ptr    <= '0;
              pre    <= 1'b1;
              pause  <= 1'b1;
            end
          end
          WRITE: begin
            // pre marks the one-clock buffer prefetch before each entry's burst.
            if (pre) begin
              pre         <= 1'b0;
              offset      <= '0;
              ram_we      <= 1'b1;
              ram_address <= cur_base[RAM_AW-1:0];
              ram_din     <= buffer[ptr];
              ptr         <= ptr + 1'b1;
            end else if (offset == len_tab[entry] - 8'd1) begin
              ram_we <= 1'b0;
              if (more) begin
                entry <= entry + 4'd1;
                pre   <= 1'b1;
              end else begin
                state      <= DONE;
                ram_access <= 1'b0;
                restored   <= 1'b1;
              end
            end else begin
              offset      <= offset + 8'd1;
              ram_address <= nxt_addr[RAM_AW-1:0];
              ram_din     <= buffer[ptr];
              ptr         <= ptr + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            pause <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HISCORE_PAUSE_EN
  assign pause_cpu = pause;
  logic unused_bits;
  assign unused_bits = ^{ioctl_addr, cur_base, end_addr, nxt_addr, nxt_base};
`else
  logic unused_bits;
  assign unused_bits = ^{ioctl_addr, cur_base, end_addr, nxt_addr, nxt_base, pause};
`endif

endmodule
